// File: rtl/imm_extend_pipe.sv
// Immediate extension (sign/zero/upper/branch) registered behind a valid/ready handshake.
// Latency: 1 cycle. Backpressure: 2-entry skid, ready_o is registered and drops only when the skid is occupied.
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHAMT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       mode_i,
    input  logic [IN_W-1:0]  data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [1:0]       mode_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               vld_q, vld_d;
    logic               rdy_q, rdy_d;
    logic [OUT_W-1:0]   out_dat_q, out_dat_d;
    logic [1:0]         out_mode_q, out_mode_d;
    logic [OUT_W-1:0]   skid_dat_q, skid_dat_d;
    logic [1:0]         skid_mode_q, skid_mode_d;

    logic [OUT_W-1:0]   sext, zext, ext_dat;
    logic               acc, drn;

    always_comb begin
        sext = OUT_W'($signed(data_i));
        zext = OUT_W'(data_i);
        unique case (mode_i)
            2'b00:   ext_dat = sext;
            2'b01:   ext_dat = zext;
            2'b10:   ext_dat = zext << (OUT_W - IN_W);
            default: ext_dat = sext << BR_SHAMT;
        endcase
    end

    assign acc = valid_i && rdy_q;
    assign drn = vld_q && ready_i;

    always_comb begin
        state_d     = state_q;
        out_dat_d   = out_dat_q;
        out_mode_d  = out_mode_q;
        skid_dat_d  = skid_dat_q;
        skid_mode_d = skid_mode_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d    = ST_ONE;
                    out_dat_d  = ext_dat;
                    out_mode_d = mode_i;
                end
            end
            ST_ONE: begin
                if (acc && drn) begin
                    out_dat_d  = ext_dat;
                    out_mode_d = mode_i;
                end else if (acc) begin
                    state_d     = ST_FULL;
                    skid_dat_d  = ext_dat;
                    skid_mode_d = mode_i;
                end else if (drn) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // ready_o is low here, so only a drain can move the state
                if (drn) begin
                    state_d     = ST_ONE;
                    out_dat_d   = skid_dat_q;
                    out_mode_d  = skid_mode_q;
                    skid_dat_d  = '0;
                    skid_mode_d = 2'b00;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        vld_d = (state_d != ST_EMPTY);
        rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_EMPTY;
            vld_q       <= 1'b0;
            rdy_q       <= 1'b1;
            out_dat_q   <= '0;
            out_mode_q  <= 2'b00;
            skid_dat_q  <= '0;
            skid_mode_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            rdy_q       <= rdy_d;
            out_dat_q   <= out_dat_d;
            out_mode_q  <= out_mode_d;
            skid_dat_q  <= skid_dat_d;
            skid_mode_q <= skid_mode_d;
        end
    end

    assign ready_o = rdy_q;
    assign valid_o = vld_q;
    assign data_o  = out_dat_q;
    assign mode_o  = out_mode_q;

endmodule
